lsu_ram_if: RTL and testbench
=============================

// Module: lsu_ram_if
// PURPOSE
//  Load/store adapter between the core's memory stage and the word-wide byte-lane RAM.
//  - Accepts one byte/half/word request at a time.
//  - Turns it into aligned word accesses with byte selects.
//  - Load data: extracts the addressed bytes and sign/zero-extends them.
//  - Accesses that cross a word boundary are split into two word accesses (see CONFIGURATION).
// PARAMETERS
//  RAM_BYTES  16384  RAM size in bytes; must be a multiple of 4.
//                    An access whose last byte is >= RAM_BYTES is an error.
// PORTS
//  clk             in   1   single clock; all state updates on posedge
//  rst_n           in   1   asynchronous, active-low reset
//  req_valid_i     in   1   request valid
//  req_ready_o     out  1   request accepted when valid && ready
//  req_we_i        in   1   1 = store, 0 = load
//  req_size_i      in   2   00 byte, 01 half, 10 word, 11 reserved (error)
//  req_unsigned_i  in   1   load zero-extend (1) / sign-extend (0)
//  req_addr_i      in   32  byte address
//  req_wdata_i     in   32  store data, right-justified
//  rsp_valid_o     out  1   one-cycle response pulse; no back-pressure
//  rsp_data_o      out  32  extended load data (0 for stores and errors)
//  rsp_err_o       out  1   access fault; qualified by rsp_valid_o
//  mem_addr_o      out  32  word-aligned RAM address; bits [1:0] = 0
//  mem_w_en_o      out  1   RAM write enable
//  mem_w_data_o    out  32  lane-shifted write data
//  mem_w_sel_o     out  4   byte-lane write select; bit k = bits [8k+7:8k]
//  mem_r_data_i    in   32  combinational RAM read data for mem_addr_o
// BEHAVIOUR
//  Reset
//  - State IDLE; request registers cleared.
//  - All outputs 0 except req_ready_o = 1.
//  Request acceptance
//  - req_ready_o = 1 only in IDLE.
//  - On acceptance, latch we/size/unsigned/addr/wdata.
//  - off = addr[1:0]; mask = 0001 / 0011 / 1111 for byte / half / word.
//  - m8 = {4'b0, mask} << off; span = |m8[7:4].
//  Error check (done at acceptance)
//  - Error if size == 11, or if addr + nbytes - 1 >= RAM_BYTES (compare without wrap).
//  - Error goes IDLE -> RESP directly: rsp_err_o = 1, no mem_w_en_o pulse.
//  States
//  - IDLE -> ACC0 -> (span ? ACC1 : RESP) -> RESP -> IDLE.
//  - ACC0: mem_addr_o = {addr[31:2], 2'b00}.
//    - Store: mem_w_en_o = 1, mem_w_sel_o = m8[3:0], mem_w_data_o = wdata << 8*off.
//    - Load: capture mem_r_data_i into buf0.
//  - ACC1: mem_addr_o = word0 + 4.
//    - Store: mem_w_sel_o = m8[7:4], mem_w_data_o = wdata >> 8*(4 - off).
//    - Load: capture mem_r_data_i into buf1.
//  - RESP: rsp_valid_o = 1 for exactly one cycle.
//    - rsp_data_o = extend(({buf1, buf0} >> 8*off) masked to size bytes).
//    - Sign bit is bit 7 (byte) or bit 15 (half).
//  - In IDLE and RESP: mem_addr_o = 0, mem_w_en_o = 0, mem_w_sel_o = 0, mem_w_data_o = 0.
//  Latency and throughput
//  - Latency from the accept edge: aligned rsp_valid_o 2 cycles later; split 3 cycles later.
//  - Throughput: at most one request per 3 (or 4 if split) cycles.
//  - A new request cannot be accepted in the RESP cycle.
//  Boundary conditions
//  - rsp_data_o and rsp_err_o are registered and hold their values until the next RESP.
//  - Reset mid-operation aborts immediately. A word0 write already performed in ACC0 stays.
//  - Word access at RAM_BYTES - 4 is legal. Half access at RAM_BYTES - 1 is an error.
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN
//  - Defined: split behaviour as above.
//  - Undefined: any request with span = 1, or half with off[0] = 1, or word with off != 0,
//    is an error. It goes to RESP with rsp_err_o = 1 and no RAM write. ACC1 is not
//    implemented.
// TESTING
//  1. Store word 0xDEADBEEF @0x10, then load word @0x10
//     -> w_sel = 1111 at addr 0x10; rsp_data = 0xDEADBEEF, err = 0, 2 cycles after accept.
//  2. Load byte @0x13 (word = 0xDEADBEEF): signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
//  3. Store half 0x1234 @0x12 -> w_sel = 1100, w_data = 0x12340000.
//     Then load half signed @0x12 -> 0x00001234.
//  4. Split (macro on): store word 0xAABBCCDD @0x21
//     -> ACC0 sel 1110, data 0xBBCCDD00 @0x20; ACC1 sel 0001, data 0x000000AA @0x24.
//     Load word @0x21 -> 0xAABBCCDD, rsp 3 cycles after accept.
//  5. Macro off, same store @0x21 -> rsp_err = 1, mem_w_en never asserted.
//     Word load @RAM_BYTES - 4 -> err = 0; half load @RAM_BYTES - 1 -> err = 1.
//  6. Assert rst_n low during ACC1 of case 4
//     -> all outputs 0 asynchronously, req_ready = 1 after release, word @0x24 unchanged.

Source files
------------

// File: rtl/lsu_ram_if.sv
// Load/store adapter: one byte/half/word request at a time, turned into aligned word RAM accesses.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses in two; otherwise they fault.
module lsu_ram_if #(
  parameter int unsigned RAM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_w_en_o,
  output logic [31:0] mem_w_data_o,
  output logic [3:0]  mem_w_sel_o,
  input  logic [31:0] mem_r_data_i
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state;
  logic        r_we;
  logic        r_uns;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0] r_wdata;
  logic [7:0]  r_m8;
  logic [31:0] buf0;
`endif

  logic [1:0]  in_off;
  logic [3:0]  in_mask;
  logic [7:0]  in_m8;
  logic        in_span;
  logic [1:0]  in_nb_m1;
  logic [32:0] in_last;
  logic        in_err;

  always_comb begin
    in_off = req_addr_i[1:0];
    case (req_size_i)
      2'b00:   begin in_mask = 4'b0001; in_nb_m1 = 2'd0; end
      2'b01:   begin in_mask = 4'b0011; in_nb_m1 = 2'd1; end
      default: begin in_mask = 4'b1111; in_nb_m1 = 2'd3; end
    endcase
    in_m8   = {4'b0000, in_mask} << in_off;
    in_span = |in_m8[7:4];
    // 33-bit sum so an access near 4 GiB cannot wrap back into range
    in_last = {1'b0, req_addr_i} + {31'b0, in_nb_m1};
    in_err  = (req_size_i == 2'b11) || (in_last >= 33'(RAM_BYTES));
`ifndef LSU_MISALIGN_SPLIT_EN
    if (in_span || (req_size_i == 2'b01 && in_off[0]) ||
        (req_size_i == 2'b10 && in_off != 2'b00))
      in_err = 1'b1;
`endif
  end

  function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    sh = pair >> {off, 3'b000};
    case (size)
      2'b00:   extract = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh[31:0];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= '0;
      r_off        <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_wdata      <= '0;
      r_m8         <= '0;
      buf0         <= '0;
`endif
      req_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_err_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_w_en_o   <= 1'b0;
      mem_w_data_o <= '0;
      mem_w_sel_o  <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            r_we        <= req_we_i;
            r_uns       <= req_unsigned_i;
            r_size      <= req_size_i;
            r_off       <= in_off;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_wdata     <= req_wdata_i;
            r_m8        <= in_m8;
`endif
            req_ready_o <= 1'b0;
            if (in_err) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_data_o  <= '0;
            end else begin
              state        <= ACC0;
              mem_addr_o   <= {req_addr_i[31:2], 2'b00};
              mem_w_en_o   <= req_we_i;
              mem_w_sel_o  <= req_we_i ? in_m8[3:0] : 4'b0000;
              mem_w_data_o <= req_we_i ? (req_wdata_i << {in_off, 3'b000}) : '0;
            end
          end
        end
        ACC0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          buf0 <= mem_r_data_i;
          if (r_m8[7:4] != 4'b0000) begin
            state        <= ACC1;
            mem_addr_o   <= mem_addr_o + 32'd4;
            mem_w_en_o   <= r_we;
            mem_w_sel_o  <= r_we ? r_m8[7:4] : 4'b0000;
            mem_w_data_o <= r_we ? (r_wdata >> (6'd32 - {1'b0, r_off, 3'b000})) : '0;
          end else begin
`endif
            // aligned: the upper word of the pair is never selected, so feed zeros
            state        <= RESP;
            rsp_valid_o  <= 1'b1;
            rsp_err_o    <= 1'b0;
            rsp_data_o   <= r_we ? '0 : extract({32'b0, mem_r_data_i}, r_off, r_size, r_uns);
            mem_addr_o   <= '0;
            mem_w_en_o   <= 1'b0;
            mem_w_sel_o  <= '0;
            mem_w_data_o <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          end
`endif
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ACC1: begin
          state        <= RESP;
          rsp_valid_o  <= 1'b1;
          rsp_err_o    <= 1'b0;
          rsp_data_o   <= r_we ? '0 : extract({mem_r_data_i, buf0}, r_off, r_size, r_uns);
          mem_addr_o   <= '0;
          mem_w_en_o   <= 1'b0;
          mem_w_sel_o  <= '0;
          mem_w_data_o <= '0;
        end
`endif
        RESP: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ram_if.sv
// Bench for lsu_ram_if: byte-array RAM plus a byte-level golden memory model.
module tb_lsu_ram_if;
  localparam int unsigned RAM_BYTES = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;
  logic        mem_w_en;
  logic [3:0]  mem_w_sel;

  lsu_ram_if #(.RAM_BYTES(RAM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .mem_addr_o(mem_addr), .mem_w_en_o(mem_w_en), .mem_w_data_o(mem_w_data),
    .mem_w_sel_o(mem_w_sel), .mem_r_data_i(mem_r_data)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram  [RAM_BYTES];
  logic [7:0]  gold [RAM_BYTES];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned wen_cnt = 0;
  logic [31:0] wr_addr [2];
  logic [3:0]  wr_sel  [2];
  logic [31:0] wr_data [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always_comb begin
    for (int k = 0; k < 4; k++)
      mem_r_data[8*k +: 8] = ram[(mem_addr + 32'(k)) % RAM_BYTES];
  end

  always @(posedge clk) begin
    if (mem_w_en)
      for (int k = 0; k < 4; k++)
        if (mem_w_sel[k]) ram[(mem_addr + 32'(k)) % RAM_BYTES] = mem_w_data[8*k +: 8];
  end

  always @(negedge clk) begin
    if (mem_w_en) begin
      if (wen_cnt < 2) begin
        wr_addr[wen_cnt] = mem_addr;
        wr_sel[wen_cnt]  = mem_w_sel;
        wr_data[wen_cnt] = mem_w_data;
      end
      wen_cnt++;
    end
  end

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    longint unsigned last;
    if (size == 2'b11) return 1'b1;
    last = longint'(addr) + longint'(1 << size) - 1;
    if (last >= longint'(RAM_BYTES)) return 1'b1;
`ifndef LSU_MISALIGN_SPLIT_EN
    if (size == 2'b01 && addr[0]) return 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
    int unsigned n;
    logic [31:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < int'(n); i++) v = v | (32'(gold[addr + 32'(i)]) << (8 * i));
    if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] data, output logic err);
    logic        e_err;
    logic [31:0] e_data;
    int          span, lat, waited;
    e_err  = model_err(size, addr);
    span   = (int'(addr[1:0]) + (1 << size) > 4) ? 1 : 0;
    e_data = (e_err || we) ? 32'h0 : model_load(size, uns, addr);
    @(negedge clk);
    wen_cnt   = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
    req_addr  = addr; req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0; data = '0; err = 1'b1;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 10);
    check("rsp_latency", 32'(lat), e_err ? 32'd1 : 32'(2 + span));
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_data", rsp_data, e_data);
    check("w_en_count", wen_cnt, (we && !e_err) ? 32'(1 + span) : 32'd0);
    data = rsp_data;
    err  = rsp_err;
    @(negedge clk);
    check("rsp_pulse", 32'(rsp_valid), 32'h0);
    check("rsp_hold", rsp_data, e_data);
    if (we && !e_err)
      for (int i = 0; i < (1 << size); i++) gold[addr + 32'(i)] = wdata[8*i +: 8];
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_data"}, rsp_data, 32'h0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_w_en"}, 32'(mem_w_en), 32'h0);
    check({tag, "_mem_w_sel"}, 32'(mem_w_sel), 32'h0);
    check({tag, "_mem_w_data"}, mem_w_data, 32'h0);
  endtask

  logic [31:0] d;
  logic        e;
  int unsigned mism;

  initial begin
    for (int i = 0; i < int'(RAM_BYTES); i++) begin
      ram[i]  = 8'($urandom);
      gold[i] = ram[i];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_uns = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_ready", 32'(req_ready), 32'h1);
    rst_n = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, d, e);
    check("t1_sel", 32'(wr_sel[0]), 32'hF);
    check("t1_addr", wr_addr[0], 32'h10);
    check("t1_wdata", wr_data[0], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e);
    check("t1_load", d, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, d, e);
    check("t2_lb", d, 32'hFFFF_FFDE);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, d, e);
    check("t2_lbu", d, 32'h0000_00DE);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, d, e);
    check("t3_sel", 32'(wr_sel[0]), 32'hC);
    check("t3_wdata", wr_data[0], 32'h1234_0000);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, d, e);
    check("t3_lh", d, 32'h0000_1234);

    do_req(1'b1, 2'b10, 1'b0, 32'h21, 32'hAABB_CCDD, d, e);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("t4_sel0", 32'(wr_sel[0]), 32'hE);
    check("t4_data0", wr_data[0], 32'hBBCC_DD00);
    check("t4_addr0", wr_addr[0], 32'h20);
    check("t4_sel1", 32'(wr_sel[1]), 32'h1);
    check("t4_data1", wr_data[1], 32'h0000_00AA);
    check("t4_addr1", wr_addr[1], 32'h24);
    do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, d, e);
    check("t4_load", d, 32'hAABB_CCDD);
`else
    check("t5_split_err", 32'(e), 32'h1);
`endif
    do_req(1'b0, 2'b10, 1'b0, RAM_BYTES - 4, 32'h0, d, e);
    check("t5_top_word_err", 32'(e), 32'h0);
    do_req(1'b0, 2'b01, 1'b0, RAM_BYTES - 1, 32'h0, d, e);
    check("t5_top_half_err", 32'(e), 32'h1);

`ifdef LSU_MISALIGN_SPLIT_EN
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, d, e);
    do_req(1'b1, 2'b10, 1'b0, 32'h24, 32'h5566_7788, d, e);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_uns = 1'b0;
    req_addr = 32'h21; req_wdata = 32'hAABB_CCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_acc1_sel", 32'(mem_w_sel), 32'h1);
    rst_n = 1'b0;
    #1 check_idle_outputs("t6_abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready", 32'(req_ready), 32'h1);
    check("t6_word24", {ram[16'h27], ram[16'h26], ram[16'h25], ram[16'h24]}, 32'h5566_7788);
    check("t6_word20", {ram[16'h23], ram[16'h22], ram[16'h21], ram[16'h20]}, 32'hBBCC_DD44);
    gold[32'h21] = 8'hDD; gold[32'h22] = 8'hCC; gold[32'h23] = 8'hBB;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, d, e);
    check("t6_load20", d, 32'hBBCC_DD44);
`else
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("t6_acc0_addr", mem_addr, 32'h30);
    rst_n = 1'b0;
    #1 check_idle_outputs("t6_abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready", 32'(req_ready), 32'h1);
`endif

    for (int n = 0; n < 300; n++) begin
      int unsigned r, s;
      logic [31:0] a;
      logic [1:0]  sz;
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, 127));
      else if (r < 9) a = RAM_BYTES - 6 + 32'($urandom_range(0, 5));
      else            a = $urandom;
      s  = $urandom_range(0, 9);
      sz = (s < 3) ? 2'b00 : (s < 6) ? 2'b01 : (s < 9) ? 2'b10 : 2'b11;
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, d, e);
    end

    mism = 0;
    for (int i = 0; i < int'(RAM_BYTES); i++) if (ram[i] !== gold[i]) mism++;
    check("ram_image", mism, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
